// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: shows a 32-bit word as 8 hex digits on a multiplexed,
// common-anode, active-low 7-segment display (nibble k on digit k).
// The word is latched once per scan frame so digits never tear. Each digit
// slot starts with an all-off gap to suppress ghosting.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (suppress leading zeros;
// digit 0 is always shown).
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  output logic [7:0]  an_o,
  output logic [7:0]  seg_o
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   frame;

  logic          cnt_wrap;
  logic          frame_start;
  logic [3:0]    nibble;
  logic          show;
  logic [7:0]    an_nxt;
  logic [7:0]    seg_nxt;

  // Hex to active-low segments {dp,g,f,e,d,c,b,a}; dp always off.
  function automatic logic [7:0] dec(input logic [3:0] n);
    logic [7:0] s;
    s = 8'hFF;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign cnt_wrap    = (cnt == CNT_LAST);
  assign frame_start = (cnt == '0) && (idx == '0);
  assign nibble      = frame[{idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lead_zero;
  // Digit k>0 is a leading zero when every nibble from k upward is zero.
  always_comb begin
    lead_zero = (idx != 3'd0) && ((frame >> {idx, 2'b00}) == 32'd0);
  end
`endif

  // Slot counter, digit index and once-per-frame word latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= '0;
    end else begin
      if (frame_start) begin
        frame <= data_i;
      end
      if (cnt_wrap) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Next output pattern; the blank gap turns segments off as well as anodes.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = '1;
    show    = (cnt >= BLANK_LIM);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (lead_zero) begin
      show = 1'b0;
    end
`endif
    if (show) begin
      an_nxt  = ~(8'b1 << idx);
      seg_nxt = dec(nibble);
    end
  end

  // Registered outputs, one cycle behind the scan position.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_o  <= '1;
      seg_o <= '1;
    end else begin
      an_o  <= an_nxt;
      seg_o <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (SCAN_DIV=4, BLANK_CYC=1).
// Expected outputs are pushed to a scoreboard queue as each cycle is driven
// and popped/compared after the following clock edge.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_i = 32'h0;
  logic [7:0]  an_o;
  logic [7:0]  seg_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    int         pos;
  } exp_t;

  exp_t sb[$];

  logic [7:0] dec_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model of the scan position and latched word.
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [31:0] m_frame = 32'h0;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst   (rst),
    .data_i(data_i),
    .an_o  (an_o),
    .seg_o (seg_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, push the expected result of the next edge,
  // then step to just after that edge.
  task automatic drive_cycle(input logic r, input logic [31:0] d);
    exp_t        e;
    logic        lit;
    logic [31:0] upper;
    @(negedge clk);
    rst    = r;
    data_i = d;
    e.an  = 8'hFF;
    e.seg = 8'hFF;
    e.pos = m_cnt;
    if (r) begin
      m_cnt   = 0;
      m_idx   = 0;
      m_frame = 32'h0;
    end else begin
      upper = m_frame >> (4 * m_idx);
      lit   = (m_cnt >= BLANK_CYC);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (m_idx != 0 && upper == 32'h0) lit = 1'b0;
`endif
      if (lit) begin
        e.an  = 8'hFF ^ (8'h01 << m_idx);
        e.seg = dec_tab[upper[3:0]];
      end
      if (m_cnt == 0 && m_idx == 0) m_frame = d;
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int n = 0; n < 3; n++) begin
      drive_cycle(1'b1, 32'h12345678);
      e = sb.pop_front();
      checks++;
      if (an_o !== 8'hFF || an_o !== e.an) begin
        errors++;
        $display("FAIL reset_an cyc=%0d got=%h want=FF", n, an_o);
      end
      checks++;
      if (seg_o !== 8'hFF || seg_o !== e.seg) begin
        errors++;
        $display("FAIL reset_seg cyc=%0d got=%h want=FF", n, seg_o);
      end
    end
    // First cycle after release: still all off.
    drive_cycle(1'b0, 32'h89ABCDEF);
    e = sb.pop_front();
    checks++;
    if (an_o !== 8'hFF || seg_o !== 8'hFF) begin
      errors++;
      $display("FAIL post_reset an=%h seg=%h want FF FF", an_o, seg_o);
    end
  endtask

  task automatic test_scan();
    exp_t e;
    for (int n = 1; n < 64; n++) begin
      drive_cycle(1'b0, 32'h89ABCDEF);
      e = sb.pop_front();
      checks++;
      if (an_o !== e.an) begin
        errors++;
        $display("FAIL scan_an cyc=%0d got=%h want=%h", n, an_o, e.an);
      end
      checks++;
      if (seg_o !== e.seg) begin
        errors++;
        $display("FAIL scan_seg cyc=%0d got=%h want=%h", n, seg_o, e.seg);
      end
      if (n == 9 || n == 41) begin
        checks++;
        if (an_o !== 8'hFB || seg_o !== 8'hA1) begin
          errors++;
          $display("FAIL scan_digit2 cyc=%0d an=%h seg=%h want FB A1", n, an_o, seg_o);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    exp_t e;
    drive_cycle(1'b1, 32'h0);
    e = sb.pop_front();
    checks++;
    if (an_o !== e.an) begin
      errors++;
      $display("FAIL tear_rst got=%h want=%h", an_o, e.an);
    end
    for (int n = 0; n < 64; n++) begin
      drive_cycle(1'b0, (n >= 13) ? 32'h0 : 32'h89ABCDEF);
      e = sb.pop_front();
      checks++;
      if (an_o !== e.an || seg_o !== e.seg) begin
        errors++;
        $display("FAIL tear_out cyc=%0d an=%h seg=%h want %h %h", n, an_o, seg_o, e.an, e.seg);
      end
      if (n == 17) begin
        checks++;
        if (an_o !== 8'hEF || seg_o !== 8'h83) begin
          errors++;
          $display("FAIL tear_old_word an=%h seg=%h want EF 83", an_o, seg_o);
        end
      end
      if (n == 33) begin
        checks++;
        if (an_o !== 8'hFE || seg_o !== 8'hC0) begin
          errors++;
          $display("FAIL tear_new_word an=%h seg=%h want FE C0", an_o, seg_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    exp_t e;
    drive_cycle(1'b1, 32'h0);
    void'(sb.pop_front());
    for (int n = 0; n < 21; n++) begin
      drive_cycle(1'b0, 32'h89ABCDEF);
      e = sb.pop_front();
      checks++;
      if (an_o !== e.an || seg_o !== e.seg) begin
        errors++;
        $display("FAIL mid_pre cyc=%0d an=%h seg=%h want %h %h", n, an_o, seg_o, e.an, e.seg);
      end
    end
    drive_cycle(1'b1, 32'h89ABCDEF);
    e = sb.pop_front();
    checks++;
    if (an_o !== 8'hFF || an_o !== e.an) begin
      errors++;
      $display("FAIL mid_rst_an got=%h want=FF", an_o);
    end
    for (int n = 0; n < 34; n++) begin
      drive_cycle(1'b0, (n == 0) ? 32'h0F1E2D3C : 32'hFFFFFFFF);
      e = sb.pop_front();
      checks++;
      if (an_o !== e.an || seg_o !== e.seg) begin
        errors++;
        $display("FAIL mid_post cyc=%0d an=%h seg=%h want %h %h", n, an_o, seg_o, e.an, e.seg);
      end
      if (n == 1) begin
        checks++;
        if (an_o !== 8'hFE || seg_o !== 8'hC6) begin
          errors++;
          $display("FAIL mid_restart an=%h seg=%h want FE C6", an_o, seg_o);
        end
      end
    end
  endtask

  task automatic test_one_hot();
    exp_t e;
    int   blanks;
    int   exp_blanks;
    drive_cycle(1'b1, 32'h0);
    void'(sb.pop_front());
    blanks     = 0;
    exp_blanks = 0;
    for (int n = 0; n < 10 * 8 * SCAN_DIV; n++) begin
      drive_cycle(1'b0, $urandom);
      e = sb.pop_front();
      checks++;
      if (an_o !== e.an || seg_o !== e.seg) begin
        errors++;
        $display("FAIL rand_out cyc=%0d an=%h seg=%h want %h %h", n, an_o, seg_o, e.an, e.seg);
      end
      checks++;
      if ($countones(~an_o) > 1) begin
        errors++;
        $display("FAIL one_hot cyc=%0d an=%h want at most one low bit", n, an_o);
      end
      if (e.pos == 0) begin
        blanks     = 0;
        exp_blanks = 0;
      end
      if (an_o === 8'hFF) blanks++;
      if (e.an == 8'hFF) exp_blanks++;
      if (e.pos == SCAN_DIV - 1) begin
        checks++;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (blanks != exp_blanks) begin
          errors++;
          $display("FAIL blank_count cyc=%0d got=%0d want=%0d", n, blanks, exp_blanks);
        end
`else
        if (blanks != BLANK_CYC) begin
          errors++;
          $display("FAIL blank_count cyc=%0d got=%0d want=%0d", n, blanks, BLANK_CYC);
        end
`endif
      end
    end
  endtask

  task automatic test_leading_zero();
    exp_t       e;
    logic [7:0] want_an3;
    logic [7:0] want_seg3;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    want_an3  = 8'hFF;
    want_seg3 = 8'hFF;
`else
    want_an3  = 8'hF7;
    want_seg3 = 8'hC0;
`endif
    drive_cycle(1'b1, 32'h0);
    void'(sb.pop_front());
    for (int n = 0; n < 96; n++) begin
      drive_cycle(1'b0, (n < 32) ? 32'h000000A5 : 32'h0);
      e = sb.pop_front();
      checks++;
      if (an_o !== e.an || seg_o !== e.seg) begin
        errors++;
        $display("FAIL lz_out cyc=%0d an=%h seg=%h want %h %h", n, an_o, seg_o, e.an, e.seg);
      end
      if (n == 5) begin
        checks++;
        if (an_o !== 8'hFD || seg_o !== 8'h88) begin
          errors++;
          $display("FAIL lz_digit1 an=%h seg=%h want FD 88", an_o, seg_o);
        end
      end
      if (n == 13 || n == 45) begin
        checks++;
        if (an_o !== want_an3 || seg_o !== want_seg3) begin
          errors++;
          $display("FAIL lz_digit3 cyc=%0d an=%h seg=%h want %h %h", n, an_o, seg_o, want_an3, want_seg3);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_reset_mid_scan();
    test_one_hot();
    test_leading_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
